// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants, next-count select encoding and load clamp helper
package counter_pkg;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  typedef enum logic [2:0] {HOLD, LOAD, INC, DEC, WRAP_LO, WRAP_HI} next_sel_e;
  function automatic logic [32:0] clamp_to_max(input logic [32:0] val, input logic [32:0] max);
    return (val > max) ? max : val;
  endfunction
endpackage

// File: rtl/counter_next_logic.sv
// counter_next_logic: combinational next-count selection and terminal detection.
// Ports: en/up/load/load_val control inputs, count current value;
//        count_d next value, wrap_d next wrap flag, tc terminal count.
// Optional COUNTER_SATURATE_EN: a step at the terminal value holds count instead of wrapping.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter longint unsigned MODULO = 10
) (
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_d,
  output logic             wrap_d,
  output logic             tc
);
  localparam logic [WIDTH:0] MAX_COUNT = (WIDTH+1)'(MODULO - 1);
  next_sel_e sel;
  logic [WIDTH:0] cnt_x, inc_x, dec_x, nxt_x;
  logic [32:0] ld_c;
  logic at_max, at_zero, unused;
  // One extra bit keeps INC/DEC free of silent overflow at the 2**WIDTH modulus.
  assign cnt_x = {1'b0, count};
  assign inc_x = cnt_x + (WIDTH+1)'(1);
  assign dec_x = cnt_x - (WIDTH+1)'(1);
  assign ld_c = clamp_to_max(33'(load_val), 33'(MAX_COUNT));
  assign at_max = cnt_x == MAX_COUNT;
  assign at_zero = cnt_x == '0;
  assign tc = en & ((up == DIR_UP) ? at_max : at_zero);
  always_comb sel = load ? LOAD : !en ? HOLD : (up == DIR_UP) ? (at_max ? WRAP_LO : INC) : (at_zero ? WRAP_HI : DEC);
  always_comb begin
    nxt_x = cnt_x;
    case (sel)
      LOAD: nxt_x = ld_c[WIDTH:0];
      INC: nxt_x = inc_x;
      DEC: nxt_x = dec_x;
`ifdef COUNTER_SATURATE_EN
      WRAP_LO, WRAP_HI: nxt_x = cnt_x;
`else
      WRAP_LO: nxt_x = '0;
      WRAP_HI: nxt_x = MAX_COUNT;
`endif
      default: nxt_x = cnt_x;
    endcase
  end
  assign count_d = nxt_x[WIDTH-1:0];
  // A blocked saturating step still reports a boundary event.
  assign wrap_d = (sel == WRAP_LO) || (sel == WRAP_HI);
  assign unused = ^{ld_c, nxt_x[WIDTH]};
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULO up/down counter with load, terminal count and wrap pulse.
// Ports: clk, rst (sync active-high), en, up, load, load_val -> count (registered),
//        tc (combinational cascade enable), wrap (registered one-cycle boundary pulse).
// Optional COUNTER_SATURATE_EN: hold at the terminal value instead of wrapping.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter longint unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] count_q, count_d;
  logic wrap_q, wrap_d;
  counter_next_logic #(.WIDTH(WIDTH), .MODULO(MODULO)) u_next (
    .en(en), .up(up), .load(load), .load_val(load_val), .count(count_q),
    .count_d(count_d), .wrap_d(wrap_d), .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q <= wrap_d;
    end
  end
  assign count = count_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed and random checks of the modulo-10 counter against a behavioural model
module tb_mod_updown_counter;
  localparam int MOD = 10;
  localparam int MAXC = MOD - 1;
  logic clk = 1'b0;
  logic rst, en, up, load, tc, wrap;
  logic [3:0] load_val, count;
  logic c_rst, c_en, c1_tc, c2_tc, c1_wrap, c2_wrap;
  logic [3:0] c1_cnt, c2_cnt;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  bit m_wrap = 1'b0;
  bit known = 1'b0;
  always #5 clk = ~clk;
  mod_updown_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap)
  );
  mod_updown_counter #(.WIDTH(4), .MODULO(10)) c1 (
    .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .count(c1_cnt), .tc(c1_tc), .wrap(c1_wrap)
  );
  mod_updown_counter #(.WIDTH(4), .MODULO(10)) c2 (
    .clk(clk), .rst(c_rst), .en(c1_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .count(c2_cnt), .tc(c2_tc), .wrap(c2_wrap)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic l, input logic e, input logic u, input logic [3:0] lv);
    int nxt;
    rst = r; load = l; en = e; up = u; load_val = lv;
    #1;
    if (known) check({tag, ".tc"}, 32'(tc), 32'(e && (u ? m_cnt == MAXC : m_cnt == 0)));
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_wrap = 1'b0; known = 1'b1;
    end else if (l) begin
      m_cnt = (int'(lv) > MAXC) ? MAXC : int'(lv); m_wrap = 1'b0;
    end else if (e) begin
      nxt = u ? m_cnt + 1 : m_cnt - 1;
      m_wrap = (nxt < 0) || (nxt > MAXC);
`ifdef COUNTER_SATURATE_EN
      if (m_wrap) nxt = m_cnt;
`else
      nxt = (nxt + MOD) % MOD;
`endif
      m_cnt = nxt;
    end else m_wrap = 1'b0;
    #1;
    if (known) begin
      check({tag, ".count"}, 32'(count), 32'(m_cnt));
      check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    end
  endtask
  initial begin
    int v, old;
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
    c_rst = 1'b1; c_en = 1'b0;
    step("rst_prio", 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 10; i++) step("up_wrap", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step("load0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) step("down_wrap", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step("clamp", 1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
    step("load_prec", 1'b0, 1'b1, 1'b1, 1'b1, 4'd4);
    step("hold", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step("rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    step("load9", 1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) step("sat_up", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step("sat_rev", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(99) < 3, $urandom_range(99) < 15, $urandom_range(99) < 70, 1'($urandom), 4'($urandom_range(15)));
`ifndef COUNTER_SATURATE_EN
    @(posedge clk);
    #1;
    c_rst = 1'b0; c_en = 1'b1;
    check("casc_rst.lo", 32'(c1_cnt), 32'd0);
    check("casc_rst.hi", 32'(c2_cnt), 32'd0);
    v = 0;
    for (int i = 0; i < 205; i++) begin
      check("casc.tc", 32'(c1_tc), 32'(v % 10 == 9));
      @(posedge clk);
      old = v;
      v = (v + 1) % 100;
      #1;
      check("casc.lo", 32'(c1_cnt), 32'(v % 10));
      check("casc.hi", 32'(c2_cnt), 32'(v / 10));
      check("casc.wrap", 32'(c2_wrap), 32'(old == 99));
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
